// File: rtl/regfile_wb.sv
// regfile_wb: write-back end of the MEM/WB stage, a 32 x 32-bit general
// register file with two combinational read ports and same-cycle
// write-to-read bypass. Register 0 reads as zero and ignores writes.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc_i              PC of the retiring instruction
//   we, waddr, wdata  write-back port from the MEM/WB register
//   re1, raddr1       read port 1 enable/address -> rdata1 (comb)
//   re2, raddr2       read port 2 enable/address -> rdata2 (comb)
//   retire_cnt        write-backs retired, wraps (optional)
//   last_pc           PC of the last retired write (optional)
//
// Optional feature macro: REGFILE_RETIRE_CNT_EN adds retire_cnt/last_pc.
// Without it pc_i is unused and no counter logic exists.

module regfile_wb #(
   parameter int NREGS = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_i,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [31:0]      wdata,
   input  logic             re1,
   input  logic [4:0]       raddr1,
   output logic [31:0]      rdata1,
   input  logic             re2,
   input  logic [4:0]       raddr2,
   output logic [31:0]      rdata2
`ifdef REGFILE_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [31:0]      last_pc
`endif
);

   logic [31:0] regs [NREGS];

   // r0 is cleared by reset and never written, so it stays zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   // Bypass lets ID see this cycle's write-back before it lands.
   always_comb begin
      rdata1 = '0;
      if (rst || raddr1 == '0 || !re1) begin
         rdata1 = '0;
      end else if (we && raddr1 == waddr) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst || raddr2 == '0 || !re2) begin
         rdata2 = '0;
      end else if (we && raddr2 == waddr) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs[raddr2];
      end
   end

`ifdef REGFILE_RETIRE_CNT_EN
   // Every retiring write counts, including writes aimed at r0.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
         last_pc    <= '0;
      end else if (we) begin
         retire_cnt <= retire_cnt + 1'b1;
         last_pc    <= pc_i;
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc_i;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and random steps for regfile_wb with a
// scoreboard queue of expected read data.

module tb_regfile_wb;

`ifdef REGFILE_RETIRE_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 32;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
`ifdef REGFILE_RETIRE_CNT_EN
   logic [CW-1:0] retire_cnt;
   logic [31:0]   last_pc;
`endif

   regfile_wb #(.NREGS(32), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .pc_i   (pc_i),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
`ifdef REGFILE_RETIRE_CNT_EN
      ,
      .retire_cnt (retire_cnt),
      .last_pc    (last_pc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mref [32];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", obs, 32'hxxxx_xxxx);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.v);
      end
   endtask

   // Drive one cycle, check both read ports before the edge, then
   // advance the reference array by what that edge will commit.
   task automatic step(input string tag, input logic r, input logic w,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1e, input logic [4:0] ra1,
                       input logic r2e, input logic [4:0] ra2,
                       input logic [31:0] e1, input logic [31:0] e2);
      @(negedge clk);
      rst = r; we = w; waddr = wa; wdata = wd;
      re1 = r1e; raddr1 = ra1; re2 = r2e; raddr2 = ra2;
      sb.push_back('{{tag, "_p1"}, e1});
      sb.push_back('{{tag, "_p2"}, e2});
      #2;
      pop_chk(rdata1);
      pop_chk(rdata2);
      if (r) begin
         for (int i = 0; i < 32; i++) mref[i] = '0;
      end else if (w && wa != 5'd0) begin
         mref[wa] = wd;
      end
   endtask

   function automatic logic [31:0] mexp(input logic r, input logic w,
                                        input logic [4:0] wa,
                                        input logic [31:0] wd,
                                        input logic e,
                                        input logic [4:0] a);
      if (r || a == 5'd0 || !e) return 32'h0;
      if (w && a == wa) return wd;
      return mref[a];
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic        w, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;

      rst = 1'b1; pc_i = '0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
      for (int i = 0; i < 32; i++) mref[i] = '0;

      step("rst0", 1, 0, 0, 0, 1, 5, 1, 5, 0, 0);
      step("w5", 0, 1, 5, 32'h1234, 1, 5, 1, 5, 32'h1234, 32'h1234);
      step("rd5", 0, 0, 0, 0, 1, 5, 1, 5, 32'h1234, 32'h1234);
      step("rst1", 1, 1, 6, 32'hAAAA, 1, 5, 1, 6, 0, 0);
      step("rst2", 1, 0, 0, 0, 1, 5, 1, 5, 0, 0);
      step("post_rst", 0, 0, 0, 0, 1, 5, 1, 6, 0, 0);

      step("byp3", 0, 1, 3, 32'hDEADBEEF, 1, 3, 0, 3,
           32'hDEADBEEF, 0);
      step("rd3", 0, 0, 0, 0, 1, 3, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);

      step("w0", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0);
      step("rd0", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

      step("w7a", 0, 1, 7, 32'h11, 1, 7, 0, 7, 32'h11, 0);
      step("w7b", 0, 1, 7, 32'h22, 1, 7, 0, 7, 32'h22, 0);

      step("r1a", 0, 1, 1, 32'h1, 1, 1, 1, 1, 32'h1, 32'h1);
      step("r1b", 0, 1, 1, 32'h2, 1, 1, 1, 1, 32'h2, 32'h2);
      step("r1c", 0, 1, 1, 32'h3, 1, 1, 1, 1, 32'h3, 32'h3);
      step("r1fin", 0, 0, 0, 0, 1, 1, 1, 7, 32'h3, 32'h22);

      step("byp_mix", 0, 1, 2, 32'h55, 1, 2, 1, 3, 32'h55, 32'hDEADBEEF);
      step("we_off_byp", 0, 0, 2, 32'h66, 1, 2, 1, 2, 32'h55, 32'h55);

      step("rst_mid", 1, 1, 8, 32'h77, 1, 8, 1, 3, 0, 0);
      step("w8", 0, 1, 8, 32'h99, 1, 8, 1, 7, 32'h99, 0);
      step("rd8", 0, 0, 0, 0, 1, 8, 1, 3, 32'h99, 0);

      for (int k = 0; k < 40; k++) begin
         w  = 1'($urandom_range(0, 1));
         wa = 5'($urandom_range(0, 7));
         wd = $urandom;
         e1 = 1'($urandom_range(0, 3) != 0);
         e2 = 1'($urandom_range(0, 3) != 0);
         a1 = 5'($urandom_range(0, 7));
         a2 = 5'($urandom_range(0, 7));
         step($sformatf("rnd%0d", k), 0, w, wa, wd, e1, a1, e2, a2,
              mexp(0, w, wa, wd, e1, a1), mexp(0, w, wa, wd, e2, a2));
      end

`ifdef REGFILE_RETIRE_CNT_EN
      step("cnt_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      sb.push_back('{"cnt_after_rst", 32'h0});
      pop_chk(32'(retire_cnt));
      for (int k = 0; k < 17; k++) begin
         pc_i = 32'h100 + 32'(4 * k);
         step($sformatf("cnt%0d", k), 0, 1, 5'(k % 4), 32'(k),
              0, 0, 0, 0, 0, 0);
      end
      step("cnt_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back('{"retire_cnt", 32'h1});
      pop_chk(32'(retire_cnt));
      sb.push_back('{"last_pc", 32'h140});
      pop_chk(last_pc);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
